// File: rtl/priority_arbiter.sv
// -----------------------------------------------------------------------------
// priority_arbiter
// Four-requester arbiter with fixed-priority or round-robin selection and an
// optional per-tenure hold limit. A grant, once issued, is kept until the owner
// drops its request or the hold limit expires. Every tenure is followed by a
// single RELEASE cycle that re-arbitrates.
//
// Parameters
//   HOLD_MAX : maximum consecutive grant cycles per tenure (0 = no limit)
//   CNT_W    : hold counter width, 2**CNT_W must exceed HOLD_MAX
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   req      : request vector, one bit per requester (3..0)
//   mode     : 0 = fixed priority (highest index wins), 1 = round-robin
//   gnt      : registered one-hot grant
//   gnt_id   : registered binary index of the granted requester
//   busy     : high while a grant is held
//   timeout  : one-cycle pulse in the RELEASE cycle entered by hold expiry
// -----------------------------------------------------------------------------
module priority_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       mode,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       gnt_id_q, gnt_id_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]       ptr_q, ptr_d;

    logic [1:0]       win_id;
    logic             win_valid;
    logic             expired;

    // Winner selection from the live request vector; only consumed in the
    // arbitration states, so mode has no effect while a grant is held.
    always_comb begin
        win_valid = |req;
        win_id    = '0;
        if (mode) begin
            // Walk from the farthest candidate back to ptr so the candidate
            // closest to ptr is assigned last and therefore wins.
            for (int k = 3; k >= 0; k--) begin
                if (req[ptr_q + 2'(k)]) begin
                    win_id = ptr_q + 2'(k);
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    win_id = 2'(i);
                end
            end
        end
    end

    assign expired = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_MAX_C);

    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d    = state_q;
        gnt_d      = '0;
        gnt_id_d   = '0;
        busy_d     = 1'b0;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        ptr_d      = ptr_q;

        unique case (state_q)
            IDLE, RELEASE: begin
                if (win_valid) begin
                    state_d    = GRANT;
                    gnt_id_d   = win_id;
                    gnt_d      = 4'b0001 << win_id;
                    busy_d     = 1'b1;
                    hold_cnt_d = CNT_ONE;
                    ptr_d      = win_id + 2'd1;
                end else begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_id_q] || expired) begin
                    // Expiry wins the timeout flag even if the request
                    // dropped in the same cycle.
                    state_d    = RELEASE;
                    timeout_d  = expired;
                    hold_cnt_d = '0;
                end else begin
                    gnt_d    = gnt_q;
                    gnt_id_d = gnt_id_q;
                    busy_d   = 1'b1;
                    if (hold_cnt_q != '1) begin
                        hold_cnt_d = hold_cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs; all of them are reset here
    // because reset must force a clean IDLE with ptr back at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// -----------------------------------------------------------------------------
// tb_priority_arbiter
// Four arbiter instances with different hold limits share one stimulus stream.
// Each is compared every cycle against a tenure-level reference model; a table
// of directed vectors and a few hand sequences pin down the documented cases.
// -----------------------------------------------------------------------------
module tb_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       mode;

    logic [3:0][3:0] gnt_a;
    logic [3:0][1:0] id_a;
    logic [3:0]      busy_a;
    logic [3:0]      to_a;

    int hold_tab [4] = '{8, 2, 3, 0};

    always #5 clk = ~clk;

    priority_arbiter #(.HOLD_MAX(8), .CNT_W(4)) u_h8 (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
        .gnt(gnt_a[0]), .gnt_id(id_a[0]), .busy(busy_a[0]), .timeout(to_a[0]));
    priority_arbiter #(.HOLD_MAX(2), .CNT_W(2)) u_h2 (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
        .gnt(gnt_a[1]), .gnt_id(id_a[1]), .busy(busy_a[1]), .timeout(to_a[1]));
    priority_arbiter #(.HOLD_MAX(3), .CNT_W(2)) u_h3 (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
        .gnt(gnt_a[2]), .gnt_id(id_a[2]), .busy(busy_a[2]), .timeout(to_a[2]));
    priority_arbiter #(.HOLD_MAX(0), .CNT_W(3)) u_h0 (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
        .gnt(gnt_a[3]), .gnt_id(id_a[3]), .busy(busy_a[3]), .timeout(to_a[3]));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: who owns the bus, for how long, and where round-robin
    // search starts next. owner < 0 means nobody holds a grant.
    int m_owner [4];
    int m_len   [4];
    int m_ptr   [4];
    bit m_to    [4];

    function automatic int pick(input logic [3:0] r, input logic m, input int p);
        if (m) begin
            for (int k = 0; k < 4; k++)
                if (r[(p + k) % 4]) return (p + k) % 4;
        end else begin
            for (int i = 3; i >= 0; i--)
                if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            m_owner[d] = -1; m_len[d] = 0; m_ptr[d] = 0; m_to[d] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [3:0] r, input logic m);
        for (int d = 0; d < 4; d++) begin
            m_to[d] = 1'b0;
            if (m_owner[d] >= 0) begin
                bit exp_lim;
                exp_lim = (hold_tab[d] != 0) && (m_len[d] == hold_tab[d]);
                if (exp_lim || !r[m_owner[d]]) begin
                    m_owner[d] = -1;
                    m_to[d]    = exp_lim;
                end else begin
                    m_len[d]++;
                end
            end else begin
                int w;
                w = pick(r, m, m_ptr[d]);
                if (w >= 0) begin
                    m_owner[d] = w;
                    m_len[d]   = 1;
                    m_ptr[d]   = (w + 1) % 4;
                end
            end
        end
    endtask

    function automatic logic [7:0] model_out(input int d);
        if (m_owner[d] >= 0)
            return {4'b0001 << m_owner[d], 2'(m_owner[d]), 1'b1, m_to[d]};
        return {4'b0000, 2'b00, 1'b0, m_to[d]};
    endfunction

    function automatic logic [7:0] dut_out(input int d);
        return {gnt_a[d], id_a[d], busy_a[d], to_a[d]};
    endfunction

    // One clock: inputs already set; model steps on the edge, outputs compared
    // 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step(req, mode);
        #1;
        for (int d = 0; d < 4; d++)
            check($sformatf("%s model h%0d", tag, hold_tab[d]), 32'(dut_out(d)), 32'(model_out(d)));
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++)
            check($sformatf("reset h%0d", hold_tab[d]), 32'(dut_out(d)), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic       mode;
        int         dut;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input bit rs, input logic [3:0] r, input logic m, input int d,
                       input logic [3:0] g, input logic [1:0] id, input logic b, input logic t);
        vec_t v;
        v.rst = rs; v.req = r; v.mode = m; v.dut = d;
        v.gnt = g; v.id = id; v.busy = b; v.to = t;
        tbl.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        mode  = 1'b0;
        model_reset();

        // Fixed priority on u_h8: 0110 -> id 2; drop req[2] -> gap -> id 1.
        add(1, 4'b0110, 0, 0, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b0110, 0, 0, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b0010, 0, 0, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0);
        // Round-robin on u_h2 with all requesting: 0,1,2,3,0, 2 cycles each.
        add(1, 4'b1111, 1, 1, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1111, 1, 1, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1111, 1, 1, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b1111, 1, 1, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b1111, 1, 1, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b1111, 1, 1, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b1111, 1, 1, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b1111, 1, 1, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b1111, 1, 1, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b1111, 1, 1, 4'b1000, 2'd3, 1, 0);
        add(0, 4'b1111, 1, 1, 4'b1000, 2'd3, 1, 0);
        add(0, 4'b1111, 1, 1, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b1111, 1, 1, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1111, 1, 1, 4'b0001, 2'd0, 1, 0);
        // Hold expiry on u_h3: three grant cycles, timeout gap, re-grant.
        add(1, 4'b0001, 0, 2, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0001, 0, 2, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0001, 0, 2, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0001, 0, 2, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b0001, 0, 2, 4'b0001, 2'd0, 1, 0);
        // No preemption on u_h0: req[3] arrives while 0 owns the grant.
        add(1, 4'b0001, 0, 3, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1001, 0, 3, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1001, 0, 3, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1001, 0, 3, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1000, 0, 3, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1000, 0, 3, 4'b1000, 2'd3, 1, 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            req  = tbl[i].req;
            mode = tbl[i].mode;
            cycle($sformatf("vec%0d", i));
            check($sformatf("vec%0d dut%0d", i, tbl[i].dut),
                  32'(dut_out(tbl[i].dut)),
                  32'({tbl[i].gnt, tbl[i].id, tbl[i].busy, tbl[i].to}));
        end

        // Mode change during a grant has no effect until next arbitration:
        // fixed picks 3, switching to round-robin mid-tenure keeps 3.
        do_reset();
        req = 4'b1001; mode = 1'b0;
        cycle("mode_a");
        check("mode_hold_a", 32'(gnt_a[0]), 32'h8);
        mode = 1'b1;
        cycle("mode_b");
        check("mode_hold_b", 32'(gnt_a[0]), 32'h8);

        // Asynchronous reset mid-grant, then round-robin restarts at ptr 0.
        do_reset();
        req = 4'b0100; mode = 1'b0;
        cycle("rst_pre");
        check("rst_pre_gnt", 32'(gnt_a[0]), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++)
            check($sformatf("rst_async h%0d", hold_tab[d]), 32'(gnt_a[d]), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 4'b1010; mode = 1'b1;
        cycle("rst_post");
        check("rst_post_gnt", 32'(gnt_a[0]), 32'h2);

        // No hold limit: continuous grant for 100 cycles, never a timeout.
        do_reset();
        req = 4'b1000; mode = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle("nolimit");
            check($sformatf("nolimit_c%0d", i), 32'({gnt_a[3], to_a[3]}), 32'({4'b1000, 1'b0}));
        end

        // Random stimulus against the model on all four instances.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3, 0) == 0) req = 4'($urandom);
            if ($urandom_range(7, 0) == 0) mode = 1'($urandom);
            if ($urandom_range(199, 0) == 0) do_reset();
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
